// File: rtl/uart_bus_bridge_burst.sv
// UART-to-bus burst bridge: write/read bursts with FIFO-buffered data,
// address auto-continue and ID / last-beat / timeout error reporting.
module uart_bus_bridge_burst #(
  parameter int              DATA_W     = 32,
  parameter int              ADDR_W     = 28,
  parameter int              ID_W       = 4,
  parameter logic [ID_W-1:0] BRIDGE_ID  = 4'hB,
  parameter int              LEN_W      = 4,
  parameter int              FIFO_DEPTH = 16,
  parameter int              ADDR_STEP  = 1,
  parameter int              TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                UnUb_cmd_valid,
  output logic                UbUn_cmd_ready,
  input  logic                UnUb_cmd_wr,
  input  logic                UnUb_cmd_cont,
  input  logic [ADDR_W-1:0]   UnUb_cmd_addr,
  input  logic [LEN_W-1:0]    UnUb_cmd_len,
  output logic                UbUn_busy,
  output logic                UbUn_done,
  output logic                UbUn_err,
  input  logic [DATA_W-1:0]   UcUb_wdata,
  input  logic                UcUb_wvalid,
  output logic                UbUc_wready,
  output logic [DATA_W-1:0]   UbUc_rdata,
  output logic                UbUc_rvalid,
  input  logic                UcUb_rready,
  output logic [ADDR_W-1:0]   UbBus_awaddr,
  output logic [ID_W-1:0]     UbBus_awid,
  output logic [LEN_W-1:0]    UbBus_awlen,
  output logic                UbBus_awvalid,
  input  logic                BusUb_awready,
  output logic [DATA_W-1:0]   UbBus_wdata,
  output logic [DATA_W/8-1:0] UbBus_wstrb,
  output logic                UbBus_wlast,
  output logic                UbBus_wvalid,
  input  logic                BusUb_wready,
  output logic [ADDR_W-1:0]   UbBus_araddr,
  output logic [ID_W-1:0]     UbBus_arid,
  output logic [LEN_W-1:0]    UbBus_arlen,
  output logic                UbBus_arvalid,
  input  logic                BusUb_arready,
  input  logic [DATA_W-1:0]   BusUb_rdata,
  input  logic [ID_W-1:0]     BusUb_rid,
  input  logic                BusUb_rlast,
  input  logic                BusUb_rvalid,
  output logic                UbBus_rready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, AW, W, AR, R, DONE} state_t;

  state_t              stateReg, stateNext;
  logic [LEN_W-1:0]    lenReg, beatReg;
  logic [ADDR_W-1:0]   startReg, nextAddrReg, burstSpan;
  logic                errReg;
  logic [TMO_W-1:0]    tmoReg;

  logic [DATA_W-1:0]   wMem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wWrPtr, wRdPtr;
  logic [PTR_W:0]      wCount;
  logic [DATA_W-1:0]   rMem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rWrPtr, rRdPtr;
  logic [PTR_W:0]      rCount;

  logic wPush, wPop, rPush, rPop, rFull;
  logic cmdAccept, awHs, arHs, rHs, ridOk, rGood, beatIsLast;
  logic active, progress, tmoHit;

  assign wPush      = UcUb_wvalid && UbUc_wready;
  assign wPop       = UbBus_wvalid && BusUb_wready;
  assign rFull      = (rCount == (PTR_W+1)'(FIFO_DEPTH));
  assign rPop       = UbUc_rvalid && UcUb_rready;
  assign cmdAccept  = UnUb_cmd_valid && UbUn_cmd_ready;
  assign awHs       = UbBus_awvalid && BusUb_awready;
  assign arHs       = UbBus_arvalid && BusUb_arready;
  assign rHs        = BusUb_rvalid && UbBus_rready;
  assign ridOk      = (BusUb_rid == BRIDGE_ID);
  assign rGood      = rHs && ridOk;
  assign rPush      = rGood;
  assign beatIsLast = (beatReg == lenReg);
  assign active     = (stateReg == AW) || (stateReg == W) || (stateReg == AR) || (stateReg == R);
  assign progress   = awHs || arHs || wPop || rHs;
  assign tmoHit     = active && !progress && (tmoReg == TMO_W'(TIMEOUT - 1));
  assign burstSpan  = (ADDR_W'(lenReg) + ADDR_W'(1)) * ADDR_W'(ADDR_STEP);

  // Write FIFO storage (contents need no reset; pointers define validity)
  always_ff @(posedge clk) begin
    if (wPush) wMem[wWrPtr] <= UcUb_wdata;
  end

  // Write FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wWrPtr <= '0;
      wRdPtr <= '0;
      wCount <= '0;
    end else begin
      if (wPush) wWrPtr <= wWrPtr + 1'b1;
      if (wPop)  wRdPtr <= wRdPtr + 1'b1;
      if (wPush && !wPop)      wCount <= wCount + 1'b1;
      else if (!wPush && wPop) wCount <= wCount - 1'b1;
    end
  end

  // Read FIFO storage
  always_ff @(posedge clk) begin
    if (rPush) rMem[rWrPtr] <= BusUb_rdata;
  end

  // Read FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rWrPtr <= '0;
      rRdPtr <= '0;
      rCount <= '0;
    end else begin
      if (rPush) rWrPtr <= rWrPtr + 1'b1;
      if (rPop)  rRdPtr <= rRdPtr + 1'b1;
      if (rPush && !rPop)      rCount <= rCount + 1'b1;
      else if (!rPush && rPop) rCount <= rCount - 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) stateReg <= IDLE;
    else        stateReg <= stateNext;
  end

  // FSM next-state logic; a timeout only fires on a cycle without progress
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: if (cmdAccept) stateNext = UnUb_cmd_wr ? AW : AR;
      AW:   if (awHs) stateNext = W;    else if (tmoHit) stateNext = DONE;
      W:    if (wPop && beatIsLast) stateNext = DONE; else if (tmoHit) stateNext = DONE;
      AR:   if (arHs) stateNext = R;    else if (tmoHit) stateNext = DONE;
      R:    if (rGood && (beatIsLast || BusUb_rlast)) stateNext = DONE;
            else if (tmoHit) stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Burst datapath: command latch, beat/timeout counters, error, continue address
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lenReg      <= '0;
      startReg    <= '0;
      nextAddrReg <= '0;
      beatReg     <= '0;
      errReg      <= 1'b0;
      tmoReg      <= '0;
    end else begin
      if (cmdAccept) begin
        lenReg   <= UnUb_cmd_len;
        startReg <= UnUb_cmd_cont ? nextAddrReg : UnUb_cmd_addr;
        errReg   <= 1'b0;
      end
      if (!active || progress) tmoReg <= '0;
      else                     tmoReg <= tmoReg + 1'b1;
      if (awHs || arHs)        beatReg <= '0;
      else if (wPop || rGood)  beatReg <= beatReg + 1'b1;
      // rlast disagreeing with the beat count flags both early and late last
      if (tmoHit || (rHs && !ridOk) || (rGood && (BusUb_rlast != beatIsLast)))
        errReg <= 1'b1;
      if (stateReg == DONE) nextAddrReg <= startReg + burstSpan;
    end
  end

  // FSM-driven outputs and bus channel fields
  always_comb begin
    UbUn_cmd_ready = (stateReg == IDLE);
    UbUn_busy      = (stateReg != IDLE);
    UbUn_done      = (stateReg == DONE);
    UbUn_err       = errReg;
    UbBus_awvalid  = (stateReg == AW);
    UbBus_arvalid  = (stateReg == AR);
    UbBus_wvalid   = (stateReg == W) && (wCount != '0);
    UbBus_wlast    = (stateReg == W) && beatIsLast;
    UbBus_rready   = (stateReg == R) && !rFull;
    UbBus_awaddr   = startReg;
    UbBus_araddr   = startReg;
    UbBus_awlen    = lenReg;
    UbBus_arlen    = lenReg;
    UbBus_awid     = BRIDGE_ID;
    UbBus_arid     = BRIDGE_ID;
    UbBus_wstrb    = '1;
    UbBus_wdata    = (wCount != '0) ? wMem[wRdPtr] : '0;
    UbUc_wready    = (wCount != (PTR_W+1)'(FIFO_DEPTH));
    UbUc_rvalid    = (rCount != '0);
    UbUc_rdata     = (rCount != '0) ? rMem[rRdPtr] : '0;
  end

endmodule

// File: tb/tb_uart_bus_bridge_burst.sv
// Scoreboard bench for uart_bus_bridge_burst: stimulus pushes expected bus and
// UART-side transactions into queues, a negedge monitor pops and compares them.
module tb_uart_bus_bridge_burst;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        UnUb_cmd_valid, UnUb_cmd_wr, UnUb_cmd_cont;
  logic [27:0] UnUb_cmd_addr;
  logic [3:0]  UnUb_cmd_len;
  logic        UbUn_cmd_ready, UbUn_busy, UbUn_done, UbUn_err;
  logic [31:0] UcUb_wdata;
  logic        UcUb_wvalid, UbUc_wready;
  logic [31:0] UbUc_rdata;
  logic        UbUc_rvalid, UcUb_rready;
  logic [27:0] UbBus_awaddr, UbBus_araddr;
  logic [3:0]  UbBus_awid, UbBus_awlen, UbBus_arid, UbBus_arlen;
  logic        UbBus_awvalid, BusUb_awready, UbBus_arvalid, BusUb_arready;
  logic [31:0] UbBus_wdata;
  logic [3:0]  UbBus_wstrb;
  logic        UbBus_wlast, UbBus_wvalid, BusUb_wready;
  logic [31:0] BusUb_rdata;
  logic [3:0]  BusUb_rid;
  logic        BusUb_rlast, BusUb_rvalid, UbBus_rready;

  int checks = 0;
  int errors = 0;
  int awvCycles = 0;

  typedef struct { logic [27:0] addr; logic [3:0] len; } axExp_t;
  typedef struct { logic [31:0] data; logic last; } wExp_t;
  axExp_t      expAw[$];
  axExp_t      expAr[$];
  wExp_t       expW[$];
  logic [31:0] expR[$];

  uart_bus_bridge_burst dut (
    .clk(clk), .rst_n(rst_n),
    .UnUb_cmd_valid(UnUb_cmd_valid), .UbUn_cmd_ready(UbUn_cmd_ready),
    .UnUb_cmd_wr(UnUb_cmd_wr), .UnUb_cmd_cont(UnUb_cmd_cont),
    .UnUb_cmd_addr(UnUb_cmd_addr), .UnUb_cmd_len(UnUb_cmd_len),
    .UbUn_busy(UbUn_busy), .UbUn_done(UbUn_done), .UbUn_err(UbUn_err),
    .UcUb_wdata(UcUb_wdata), .UcUb_wvalid(UcUb_wvalid), .UbUc_wready(UbUc_wready),
    .UbUc_rdata(UbUc_rdata), .UbUc_rvalid(UbUc_rvalid), .UcUb_rready(UcUb_rready),
    .UbBus_awaddr(UbBus_awaddr), .UbBus_awid(UbBus_awid), .UbBus_awlen(UbBus_awlen),
    .UbBus_awvalid(UbBus_awvalid), .BusUb_awready(BusUb_awready),
    .UbBus_wdata(UbBus_wdata), .UbBus_wstrb(UbBus_wstrb), .UbBus_wlast(UbBus_wlast),
    .UbBus_wvalid(UbBus_wvalid), .BusUb_wready(BusUb_wready),
    .UbBus_araddr(UbBus_araddr), .UbBus_arid(UbBus_arid), .UbBus_arlen(UbBus_arlen),
    .UbBus_arvalid(UbBus_arvalid), .BusUb_arready(BusUb_arready),
    .BusUb_rdata(BusUb_rdata), .BusUb_rid(BusUb_rid), .BusUb_rlast(BusUb_rlast),
    .BusUb_rvalid(BusUb_rvalid), .UbBus_rready(UbBus_rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitor: every handshake the DUT takes part in is compared against its queue
  always @(negedge clk) begin
    axExp_t ea;
    wExp_t  ew;
    logic [31:0] er;
    if (rst_n) begin
      if (UbBus_awvalid) awvCycles++;
      if (UbBus_awvalid && BusUb_awready) begin
        if (expAw.size() == 0) flag("unexpected_aw");
        else begin
          ea = expAw.pop_front();
          $display("AW addr=0x%0h len=%0d id=0x%0h", UbBus_awaddr, UbBus_awlen, UbBus_awid);
          check("awaddr", UbBus_awaddr, ea.addr);
          check("awlen", UbBus_awlen, ea.len);
          check("awid", UbBus_awid, 4'hB);
        end
      end
      if (UbBus_wvalid && BusUb_wready) begin
        if (expW.size() == 0) flag("unexpected_w");
        else begin
          ew = expW.pop_front();
          $display("W  data=0x%0h last=%0b", UbBus_wdata, UbBus_wlast);
          check("wdata", UbBus_wdata, ew.data);
          check("wlast", UbBus_wlast, ew.last);
          check("wstrb", UbBus_wstrb, 4'hF);
        end
      end
      if (UbBus_arvalid && BusUb_arready) begin
        if (expAr.size() == 0) flag("unexpected_ar");
        else begin
          ea = expAr.pop_front();
          $display("AR addr=0x%0h len=%0d id=0x%0h", UbBus_araddr, UbBus_arlen, UbBus_arid);
          check("araddr", UbBus_araddr, ea.addr);
          check("arlen", UbBus_arlen, ea.len);
          check("arid", UbBus_arid, 4'hB);
        end
      end
      if (UbUc_rvalid && UcUb_rready) begin
        if (expR.size() == 0) flag("unexpected_rdata");
        else begin
          er = expR.pop_front();
          $display("RD data=0x%0h", UbUc_rdata);
          check("uart_rdata", UbUc_rdata, er);
        end
      end
    end
  end

  task automatic pushW(input logic [31:0] d, input logic last);
    int n = 0;
    @(posedge clk); #1;
    while (!UbUc_wready && n < 50) begin @(posedge clk); #1; n++; end
    if (!UbUc_wready) flag("pushW_blocked");
    UcUb_wvalid = 1'b1;
    UcUb_wdata  = d;
    expW.push_back('{data: d, last: last});
    @(posedge clk); #1;
    UcUb_wvalid = 1'b0;
  endtask

  task automatic issueCmd(input logic wr, input logic cont, input logic [27:0] addr, input logic [3:0] len);
    int n = 0;
    @(negedge clk);
    while (!UbUn_cmd_ready && n < 400) begin @(negedge clk); n++; end
    if (!UbUn_cmd_ready) flag("cmd_ready_timeout");
    UnUb_cmd_valid = 1'b1;
    UnUb_cmd_wr    = wr;
    UnUb_cmd_cont  = cont;
    UnUb_cmd_addr  = addr;
    UnUb_cmd_len   = len;
    @(posedge clk); #1;
    UnUb_cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (!UbUn_done && n < budget) begin @(negedge clk); n++; end
    if (!UbUn_done) flag(name);
  endtask

  task automatic rBeat(input logic [31:0] d, input logic [3:0] id, input logic last, output int waited);
    waited = 0;
    @(negedge clk);
    BusUb_rvalid = 1'b1;
    BusUb_rdata  = d;
    BusUb_rid    = id;
    BusUb_rlast  = last;
    while (!UbBus_rready && waited < 300) begin @(negedge clk); waited++; end
    if (!UbBus_rready) flag("rbeat_timeout");
    @(posedge clk); #1;
    BusUb_rvalid = 1'b0;
  endtask

  task automatic drainR(input string name, input int expCount);
    int n = 0;
    @(posedge clk); #1;
    UcUb_rready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!UbUc_rvalid) break;
      n++;
    end
    UcUb_rready = 1'b0;
    check(name, n, expCount);
  endtask

  initial begin
    int wt;
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int wt;
    rst_n = 1'b0;
    UnUb_cmd_valid = 0; UnUb_cmd_wr = 0; UnUb_cmd_cont = 0; UnUb_cmd_addr = '0; UnUb_cmd_len = '0;
    UcUb_wdata = '0; UcUb_wvalid = 0; UcUb_rready = 0;
    BusUb_awready = 1; BusUb_wready = 1; BusUb_arready = 1;
    BusUb_rdata = '0; BusUb_rid = '0; BusUb_rlast = 0; BusUb_rvalid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", UbUn_cmd_ready, 1'b1);
    check("rst_busy_done_err", {UbUn_busy, UbUn_done, UbUn_err}, 3'b000);
    check("rst_valids", {UbBus_awvalid, UbBus_wvalid, UbBus_arvalid, UbUc_rvalid, UbBus_rready}, 5'b0);
    check("rst_fields", {UbBus_awaddr, UbBus_araddr, UbBus_awlen, UbBus_wdata}, 92'h0);
    check("rst_ids", {UbBus_awid, UbBus_arid}, 8'hBB);
    rst_n = 1'b1;

    // Write burst of 4 preloaded words
    pushW(32'h11, 0); pushW(32'h22, 0); pushW(32'h33, 0); pushW(32'h44, 1);
    expAw.push_back('{addr: 28'h100, len: 4'd3});
    issueCmd(1, 0, 28'h100, 4'd3);
    @(negedge clk);
    check("aw_latency", UbBus_awvalid, 1'b1);
    waitDone("wr1_done", 50);
    check("wr1_err", UbUn_err, 1'b0);
    @(negedge clk);
    check("done_pulse_width", UbUn_done, 1'b0);

    // Continued read of 2 beats: address must be 0x104
    UcUb_rready = 1'b1;
    expAr.push_back('{addr: 28'h104, len: 4'd1});
    expR.push_back(32'hA5A5A5A5); expR.push_back(32'h5A5A5A5A);
    issueCmd(0, 1, 28'h0, 4'd1);
    @(negedge clk);
    check("ar_latency", UbBus_arvalid, 1'b1);
    rBeat(32'hA5A5A5A5, 4'hB, 0, wt);
    rBeat(32'h5A5A5A5A, 4'hB, 1, wt);
    waitDone("rd1_done", 10);
    check("rd1_err", UbUn_err, 1'b0);
    repeat (3) @(posedge clk);
    #1 UcUb_rready = 1'b0;

    // Read with a stray ID beat and an early last
    expAr.push_back('{addr: 28'h200, len: 4'd3});
    expR.push_back(32'h11110001); expR.push_back(32'h11110002);
    issueCmd(0, 0, 28'h200, 4'd3);
    rBeat(32'h11110001, 4'hB, 0, wt);
    rBeat(32'hDEADBEEF, 4'h3, 0, wt);
    @(negedge clk);
    check("rd2_err_after_stray", UbUn_err, 1'b1);
    check("rd2_busy_after_stray", UbUn_busy, 1'b1);
    rBeat(32'h11110002, 4'hB, 1, wt);
    waitDone("rd2_done", 10);
    check("rd2_err", UbUn_err, 1'b1);
    drainR("rd2_fifo_words", 2);

    // Write that times out on AW; the preloaded word must survive
    BusUb_awready = 1'b0;
    pushW(32'h99, 1);
    awvCycles = 0;
    issueCmd(1, 0, 28'h300, 4'd0);
    waitDone("tmo_done", 400);
    check("tmo_err", UbUn_err, 1'b1);
    check("tmo_awvalid_dropped", UbBus_awvalid, 1'b0);
    check("tmo_awvalid_cycles", awvCycles, 255);
    @(negedge clk);
    check("tmo_idle", {UbUn_cmd_ready, UbUn_busy}, 2'b10);

    // Next command clears err; continue address is 0x301 after the aborted burst
    BusUb_awready = 1'b1;
    expAw.push_back('{addr: 28'h301, len: 4'd0});
    issueCmd(1, 1, 28'h0, 4'd0);
    @(negedge clk);
    check("err_cleared_on_accept", UbUn_err, 1'b0);
    waitDone("wr2_done", 20);
    check("wr2_err", UbUn_err, 1'b0);

    // 16-beat read into the 16-deep FIFO with the UART not popping
    expAr.push_back('{addr: 28'h400, len: 4'd15});
    issueCmd(0, 0, 28'h400, 4'd15);
    for (int i = 0; i < 16; i++) begin
      expR.push_back(32'h1000 + i);
      rBeat(32'h1000 + i, 4'hB, (i == 15), wt);
      if (i > 0) check($sformatf("rready_beat%0d", i), wt, 0);
    end
    waitDone("rd3_done", 10);
    check("rd3_full_rready", {UbBus_rready, UbUc_rvalid, UbUn_err}, 3'b010);
    drainR("rd3_fifo_words", 16);

    // Reset in the middle of a write burst
    BusUb_wready = 1'b0;
    pushW(32'h51, 0);
    pushW(32'h52, 0);
    pushW(32'h53, 0);
    pushW(32'h54, 1);
    void'(expW.pop_back()); void'(expW.pop_back()); void'(expW.pop_back());
    expAw.push_back('{addr: 28'h500, len: 4'd3});
    issueCmd(1, 0, 28'h500, 4'd3);
    wt = 0;
    do begin @(posedge clk); #1; wt++; end while (!UbBus_wvalid && wt < 20);
    if (!UbBus_wvalid) flag("rst_test_no_wvalid");
    BusUb_wready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    BusUb_wready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_valids", {UbBus_awvalid, UbBus_wvalid, UbBus_arvalid, UbUc_rvalid}, 4'b0);
    check("midrst_busy", {UbUn_busy, UbUn_done}, 2'b00);
    check("midrst_wready", UbUc_wready, 1'b1);
    rst_n = 1'b1;

    // Flushed FIFO and cleared continue address: new word goes to address 0
    BusUb_wready = 1'b1;
    pushW(32'h77, 1);
    expAw.push_back('{addr: 28'h0, len: 4'd0});
    issueCmd(1, 1, 28'h0, 4'd0);
    waitDone("wr3_done", 20);
    check("wr3_err", UbUn_err, 1'b0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("left_aw", expAw.size(), 0);
    check("left_w", expW.size(), 0);
    check("left_ar", expAr.size(), 0);
    check("left_r", expR.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_bus_bridge_burst.md
Name: uart_bus_bridge_burst

Overview:
- Parametrised bridge between the UART command/data path (uart_unit, uart_ctrl) and the system bus.
- Runs single- or multi-beat write and read bursts.
- Buffers write data and read data in FIFOs, uses full valid/ready handshakes on every channel, and supports address auto-continue.
- Reports errors: ID mismatch, early or late last beat, and timeout.

Parameters:
DATA_W, 32, bus/UART data width (multiple of 8)
ADDR_W, 28, bus address width
ID_W, 4, transaction ID width
BRIDGE_ID, 4'hB, ID driven on awid/arid and expected on rid
LEN_W, 4, burst length field width (beats = len+1)
FIFO_DEPTH, 16, depth of write and read FIFOs (power of two, >= 2^LEN_W)
ADDR_STEP, 1, address increment per beat
TIMEOUT, 255, max cycles without handshake progress before abort

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
UnUb_cmd_valid  in  1  command request
UbUn_cmd_ready  out  1  command accepted when both high
UnUb_cmd_wr  in  1  1=write burst, 0=read burst
UnUb_cmd_cont  in  1  1=use continued address instead of UnUb_cmd_addr
UnUb_cmd_addr  in  ADDR_W  burst start address
UnUb_cmd_len  in  LEN_W  beats-1
UbUn_busy  out  1  burst in progress
UbUn_done  out  1  one-cycle pulse at burst end
UbUn_err  out  1  sticky error, cleared on next command accept
UcUb_wdata  in  DATA_W  write data from uart_ctrl
UcUb_wvalid  in  1  write data valid
UbUc_wready  out  1  write FIFO not full
UbUc_rdata  out  DATA_W  read data to uart_ctrl
UbUc_rvalid  out  1  read FIFO not empty
UcUb_rready  in  1  uart_ctrl pops read data
UbBus_awaddr/awid/awlen/awvalid  out  ADDR_W/ID_W/LEN_W/1  write address channel
BusUb_awready  in  1
UbBus_wdata/wstrb/wlast/wvalid  out  DATA_W/DATA_W/8/1/1  write data channel
BusUb_wready  in  1
UbBus_araddr/arid/arlen/arvalid  out  ADDR_W/ID_W/LEN_W/1  read address channel
BusUb_arready  in  1
BusUb_rdata/rid/rlast/rvalid  in  DATA_W/ID_W/1/1  read data channel
UbBus_rready  out  1  read FIFO not full

Behaviour:
- Reset (rst_n low at posedge):
  - State IDLE; both FIFOs flushed.
  - All valid outputs 0; awaddr/araddr/len/wdata 0; ids = BRIDGE_ID.
  - busy/done/err 0; continued-address register 0.
  - Reset mid-burst aborts immediately, with no further bus beats.
- FIFOs:
  - Write FIFO pushes on UcUb_wvalid&&UbUc_wready in any state, so the UART can preload data before issuing a command.
  - Read FIFO pops on UbUc_rvalid&&UcUb_rready.
  - Simultaneous push and pop keeps the count unchanged; push to a full FIFO is impossible.
- UbUn_cmd_ready = (state==IDLE). On accept:
  - Latch wr, len, start = cont ? next_addr : cmd_addr.
  - Clear err; go to AW (wr) or AR (rd).
- AW:
  - awvalid=1, awaddr=start, awlen=len, held stable until BusUb_awready.
  - Then go to W with beat counter = 0.
- W:
  - wvalid = write FIFO non-empty; wdata = FIFO head; wstrb all ones.
  - wlast = (beat==len).
  - Each wvalid&&wready pops the FIFO and increments beat.
  - The wlast beat ends the burst → DONE.
- AR:
  - arvalid=1, araddr=start, arlen=len, held until BusUb_arready.
  - Then go to R with beat = 0.
- R:
  - UbBus_rready = read FIFO not full.
  - A beat is accepted on rvalid&&rready.
  - rid != BRIDGE_ID: beat dropped, not counted, err set.
  - Valid beat: pushed to FIFO, beat increments.
  - rlast on beat<len: err set, go to DONE.
  - beat==len without rlast: err set, go to DONE (late beats are ignored afterwards, since rready=0 outside R).
- DONE:
  - One cycle; done=1.
  - next_addr = start + (len+1)*ADDR_STEP, wrapping modulo 2^ADDR_W.
  - Return to IDLE.
- Timeout:
  - Counter resets on each handshake in AW/W/AR/R and increments otherwise.
  - Reaching TIMEOUT: err=1, deassert valids, go to DONE. next_addr is still updated.
  - Unsent write FIFO data is retained.
- busy = (state != IDLE).
- Latency:
  - Command accept → awvalid/arvalid: 1 cycle.
  - Bus read beat → UbUc_rvalid: 1 cycle.

Test Plan:
- Preload 4 words 0x11..0x44; command wr addr=0x100 len=3, bus always ready → AW addr 0x100 len 3, then 4 W beats in order with wlast on the 4th; done pulse; next_addr = 0x104.
- Command rd cont=1 len=1 after the above; bus returns rid=0xB words 0xA5A5A5A5, 0x5A5A5A5A with rlast on beat 2 → araddr=0x104; both words appear on UbUc_rdata; err=0.
- Read len=3 with one rid=0x3 beat inserted, then an early rlast on beat 2 → stray beat dropped; err=1; done; only 2 words in the read FIFO.
- Write len=0 with awready held low 255 cycles → err=1 at timeout, awvalid dropped, state IDLE; the next command accept clears err.
- Read len=15 with UcUb_rready=0 and FIFO_DEPTH=16 → rready stays high for 16 beats; the FIFO fills, then rready=0; the following pops re-enable rready with no data loss.
- Assert rst_n=0 during W beat 2 → next cycle all valids 0, FIFOs empty, busy=0.
